// File: rtl/dds_voice_scheduler.sv
// dds_voice_scheduler
// Shares one waveform shaper (sine table / form-wave unit) among VOICES DDS
// voices. Each sample tick starts a frame: every enabled voice issues its
// phase to the shaper over a request/ready handshake. Tagged results are
// collected into staging slots, possibly out of order, and are published to
// VOICE_OUT in one edge at the end of the frame.
//
// Ports
//   CLK, RESET            clock, synchronous active-low reset
//   SAMPLE_TICK           starts a frame (dropped and flagged if BUSY)
//   CFG_WE/ADDR/INC/EN/FORM  per-voice tuning word, enable, form write
//   OVR_CLR               clears the sticky OVERRUN flag
//   SH_REQ/RDY/PHASE/FORM/TAG  issue side of the shaper handshake
//   SH_VALID/RTAG/DATA    tagged result return from the shaper
//   VOICE_OUT             published samples, voice i at [i*OUT_W +: OUT_W]
//   FRAME_DONE            one-cycle pulse while the publish happens
//   BUSY                  frame in progress
//   OVERRUN               sticky: a tick arrived while BUSY
module dds_voice_scheduler #(
  parameter int VOICES  = 4,
  parameter int IDX_W   = 2,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SAMPLE_TICK,
  input  logic                    CFG_WE,
  input  logic [IDX_W-1:0]        CFG_ADDR,
  input  logic [PHASE_W-1:0]      CFG_INC,
  input  logic                    CFG_EN,
  input  logic [2:0]              CFG_FORM,
  input  logic                    OVR_CLR,
  output logic                    SH_REQ,
  input  logic                    SH_RDY,
  output logic [PHASE_W-1:0]      SH_PHASE,
  output logic [2:0]              SH_FORM,
  output logic [IDX_W-1:0]        SH_TAG,
  input  logic                    SH_VALID,
  input  logic [IDX_W-1:0]        SH_RTAG,
  input  logic [OUT_W-1:0]        SH_DATA,
  output logic [VOICES*OUT_W-1:0] VOICE_OUT,
  output logic                    FRAME_DONE,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(VOICES - 1);
  localparam logic [IDX_W:0]   OUT_ONE  = (IDX_W + 1)'(1);

  state_t               state, state_nxt;
  logic [PHASE_W-1:0]   phase   [VOICES];
  logic [PHASE_W-1:0]   inc     [VOICES];
  logic [2:0]           form    [VOICES];
  logic [OUT_W-1:0]     staging [VOICES];
  logic [VOICES-1:0]    en;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W:0]       outstanding;   // one extra bit: up to VOICES in flight

  logic handshake, valid_ok, slot_done, drain_empty, frame_start;

  assign handshake   = SH_REQ & SH_RDY;
  // A result with nothing in flight is stray; dropping it keeps the counter
  // from underflowing and stale tags out of the staging slots.
  assign valid_ok    = SH_VALID & (outstanding != '0);
  // A disabled voice still burns its slot cycle so the frame timing is fixed.
  assign slot_done   = (state == S_ISSUE) & (~en[ptr] | SH_RDY);
  // Look through the result arriving this cycle so DONE follows the last
  // result by exactly one cycle.
  assign drain_empty = (outstanding == '0) | ((outstanding == OUT_ONE) & SH_VALID);
  assign frame_start = (state == S_IDLE) & SAMPLE_TICK;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_nxt unassigned, which would infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (SAMPLE_TICK)            state_nxt = S_ISSUE;
      S_ISSUE: if (slot_done && ptr == PTR_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_empty)            state_nxt = S_DONE;
      S_DONE:                              state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Phase/form/tag come straight from the registers at ptr, which
  // do not move until the handshake, so they hold while SH_RDY is low.
  always_comb begin
    SH_REQ     = (state == S_ISSUE) & en[ptr];
    SH_PHASE   = phase[ptr];
    SH_FORM    = form[ptr];
    SH_TAG     = ptr;
    FRAME_DONE = (state == S_DONE);
    BUSY       = (state != S_IDLE);
  end

  // Slot pointer and in-flight counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!RESET) begin
      ptr         <= '0;
      outstanding <= '0;
    end else begin
      if (frame_start)    ptr <= '0;
      else if (slot_done) ptr <= ptr + PTR_ONE;

      unique case ({handshake, valid_ok})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Per-voice configuration, phase accumulators and staging slots.
  always_ff @(posedge CLK) begin
    // NOTE: these small register arrays are reset explicitly because a
    // restarted frame must start from phase 0 and publish zeros; large RAMs
    // would normally be left unreset.
    if (!RESET) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i]   <= '0;
        inc[i]     <= '0;
        form[i]    <= '0;
        staging[i] <= '0;
      end
      en <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        // The handshake reads the pre-edge inc/form; a write lands after it.
        if (CFG_WE && CFG_ADDR == IDX_W'(i)) begin
          inc[i]  <= CFG_INC;
          en[i]   <= CFG_EN;
          form[i] <= CFG_FORM;
        end

        // Disabling a voice zeroes its phase, even over a same-cycle advance.
        if (CFG_WE && CFG_ADDR == IDX_W'(i) && !CFG_EN)
          phase[i] <= '0;
        else if (handshake && ptr == IDX_W'(i))
          phase[i] <= phase[i] + inc[i];

        if (valid_ok && SH_RTAG == IDX_W'(i))
          staging[i] <= SH_DATA;
        else if (frame_start && !en[i])
          staging[i] <= '0;
      end
    end
  end

  // Atomic publish and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      VOICE_OUT <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      if (state == S_DONE)
        for (int i = 0; i < VOICES; i++)
          VOICE_OUT[i*OUT_W +: OUT_W] <= staging[i];

      // A fresh overrun beats a simultaneous clear.
      if (SAMPLE_TICK && BUSY) OVERRUN <= 1'b1;
      else if (OVR_CLR)        OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Self-checking bench for dds_voice_scheduler. A shaper model answers
// handshakes with tagged results (fixed latency, manual order, or random
// order). A frame-level model tracks per-voice phase, enable, form and tuning
// word and predicts the issue sequence and the published samples.
module tb_dds_voice_scheduler;
  localparam int VOICES  = 4;
  localparam int IDX_W   = 2;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 8;

  logic                    CLK = 1'b0;
  logic                    RESET, SAMPLE_TICK, CFG_WE, CFG_EN, OVR_CLR;
  logic [IDX_W-1:0]        CFG_ADDR;
  logic [PHASE_W-1:0]      CFG_INC;
  logic [2:0]              CFG_FORM;
  logic                    SH_REQ, SH_RDY, SH_VALID;
  logic [PHASE_W-1:0]      SH_PHASE;
  logic [2:0]              SH_FORM;
  logic [IDX_W-1:0]        SH_TAG, SH_RTAG;
  logic [OUT_W-1:0]        SH_DATA;
  logic [VOICES*OUT_W-1:0] VOICE_OUT;
  logic                    FRAME_DONE, BUSY, OVERRUN;

  dds_voice_scheduler #(.VOICES(VOICES), .IDX_W(IDX_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_INC(CFG_INC), .CFG_EN(CFG_EN), .CFG_FORM(CFG_FORM),
    .OVR_CLR(OVR_CLR),
    .SH_REQ(SH_REQ), .SH_RDY(SH_RDY), .SH_PHASE(SH_PHASE), .SH_FORM(SH_FORM), .SH_TAG(SH_TAG),
    .SH_VALID(SH_VALID), .SH_RTAG(SH_RTAG), .SH_DATA(SH_DATA),
    .VOICE_OUT(VOICE_OUT), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- shaper model ----------------
  typedef struct { int due; logic [IDX_W-1:0] tag; logic [OUT_W-1:0] data; } resp_t;
  typedef struct { int cyc; logic [IDX_W-1:0] tag; logic [PHASE_W-1:0] phase; logic [2:0] form; } hs_t;

  resp_t pend[$];
  hs_t   hlog[$];
  int    cyc = 0;
  int    lat = 2;
  bit    auto_resp = 1'b1;
  bit    rand_mode = 1'b0;
  int    stall_left = 0;
  logic [IDX_W-1:0] stall_tag = '0;

  function automatic logic [OUT_W-1:0] shape(input logic [PHASE_W-1:0] ph, input logic [2:0] f);
    return ph[PHASE_W-1 -: OUT_W] ^ OUT_W'(f);
  endfunction

  // Advance to the middle of the next cycle and drive the shaper inputs for it.
  task automatic cyc_end();
    int elig[$];
    int pick;
    @(negedge CLK);
    cyc++;
    SH_VALID = 1'b0; SH_RTAG = '0; SH_DATA = '0;
    foreach (pend[i]) if (pend[i].due <= cyc) elig.push_back(i);
    if (elig.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
      pick = rand_mode ? elig[$urandom_range(elig.size() - 1)] : elig[0];
      SH_VALID = 1'b1; SH_RTAG = pend[pick].tag; SH_DATA = pend[pick].data;
      pend.delete(pick);
    end
    SH_RDY = 1'b1;
    if (stall_left > 0 && SH_REQ && SH_TAG == stall_tag) begin
      SH_RDY = 1'b0;
      stall_left--;
    end else if (rand_mode) begin
      SH_RDY = ($urandom_range(3) != 0);
    end
    if (SH_REQ && SH_RDY) begin
      hlog.push_back('{cyc, SH_TAG, SH_PHASE, SH_FORM});
      if (auto_resp)
        pend.push_back('{rand_mode ? cyc + 1 + int'($urandom_range(4)) : cyc + lat,
                         SH_TAG, shape(SH_PHASE, SH_FORM)});
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [PHASE_W-1:0]      m_phase[VOICES], m_inc[VOICES], e_ph[VOICES];
  logic [2:0]              m_form[VOICES], e_form[VOICES];
  bit                      m_en[VOICES], e_en[VOICES];
  logic [VOICES*OUT_W-1:0] e_out;

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_phase[v] = '0; m_inc[v] = '0; m_form[v] = '0; m_en[v] = 1'b0;
    end
  endtask

  // Predict one frame and advance the accumulators of the enabled voices.
  task automatic model_frame();
    e_out = '0;
    for (int v = 0; v < VOICES; v++) begin
      e_en[v] = m_en[v]; e_ph[v] = m_phase[v]; e_form[v] = m_form[v];
      if (m_en[v]) begin
        e_out[v*OUT_W +: OUT_W] = shape(m_phase[v], m_form[v]);
        m_phase[v] = m_phase[v] + m_inc[v];
      end
    end
  endtask

  task automatic cfg(input int v, input logic [PHASE_W-1:0] inc, input bit en, input logic [2:0] form);
    CFG_WE = 1'b1; CFG_ADDR = IDX_W'(v); CFG_INC = inc; CFG_EN = en; CFG_FORM = form;
    cyc_end();
    CFG_WE = 1'b0;
    m_inc[v] = inc; m_en[v] = en; m_form[v] = form;
    if (!en) m_phase[v] = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (FRAME_DONE !== 1'b1 && n < budget) begin
      cyc_end();
      n++;
    end
    check({name, " frame_done seen"}, FRAME_DONE, 1'b1);
  endtask

  task automatic check_issues(input string name);
    int k = 0;
    for (int v = 0; v < VOICES; v++) if (e_en[v]) k++;
    check({name, " issue count"}, hlog.size(), k);
    k = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (e_en[v]) begin
        if (k < hlog.size())
          check({name, " issue tag/phase/form"}, {hlog[k].tag, hlog[k].phase, hlog[k].form},
                {IDX_W'(v), e_ph[v], e_form[v]});
        k++;
      end
    end
  endtask

  task automatic run_frame(input string name, output int off, output int t0);
    hlog.delete();
    model_frame();
    SAMPLE_TICK = 1'b1; t0 = cyc;
    cyc_end();
    SAMPLE_TICK = 1'b0;
    wait_done(200, name);
    off = cyc - t0;
    check_issues(name);
    cyc_end();
    check({name, " frame_done one cycle"}, FRAME_DONE, 1'b0);
    check({name, " voice_out"}, VOICE_OUT, e_out);
  endtask

  // ---------------- directed frame table ----------------
  typedef struct { logic [VOICES-1:0] mask; logic [PHASE_W-1:0] inc; int lat; int exp_off; } vec_t;
  vec_t tbl[7];

  initial begin
    int off, t0, n, stalls, cnt2;
    logic [PHASE_W-1:0] held;
    logic [PHASE_W-1:0] wrap_exp[4];
    int ooo[4];

    tbl[0] = '{4'b1111, 32'h0100_0000, 2, 7};
    tbl[1] = '{4'b0000, 32'h0000_0000, 2, 6};
    tbl[2] = '{4'b0101, 32'h0100_0000, 2, 6};
    tbl[3] = '{4'b1111, 32'h0300_0001, 1, 6};
    tbl[4] = '{4'b0001, 32'h0010_0000, 5, 7};
    tbl[5] = '{4'b1111, 32'h7FFF_FFFF, 4, 9};
    tbl[6] = '{4'b1000, 32'h0123_4567, 3, 8};
    wrap_exp = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    ooo = '{3, 0, 2, 1};

    RESET = 1'b0; SAMPLE_TICK = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_INC = '0;
    CFG_EN = 1'b0; CFG_FORM = '0; OVR_CLR = 1'b0;
    SH_RDY = 1'b1; SH_VALID = 1'b0; SH_RTAG = '0; SH_DATA = '0;
    model_reset();

    // Reset state.
    repeat (3) cyc_end();
    RESET = 1'b1;
    check("reset voice_out", VOICE_OUT, '0);
    check("reset overrun", OVERRUN, 1'b0);
    check("reset busy", BUSY, 1'b0);
    check("reset sh_req", SH_REQ, 1'b0);
    check("reset frame_done", FRAME_DONE, 1'b0);

    // Latency and first published samples.
    for (int v = 0; v < VOICES; v++) cfg(v, 32'h0100_0000, 1'b1, 3'd0);
    lat = 2;
    run_frame("frame1", off, t0);
    check("frame1 done offset", off, 7);
    for (int i = 0; i < VOICES; i++)
      if (i < hlog.size()) begin
        check("frame1 issue cycle", hlog[i].cyc - t0, i + 1);
        check("frame1 issue phase", hlog[i].phase, 32'h0);
      end
    run_frame("frame2", off, t0);
    check("frame2 voice_out 0x01", VOICE_OUT, 32'h0101_0101);

    // Phase wrap on voice 1.
    cfg(0, '0, 1'b0, 3'd0); cfg(2, '0, 1'b0, 3'd0); cfg(3, '0, 1'b0, 3'd0);
    cfg(1, 32'h1, 1'b0, 3'd0); cfg(1, 32'h1, 1'b1, 3'd0);
    run_frame("wrap pre", off, t0);
    run_frame("wrap pre", off, t0);
    cfg(1, 32'hFFFF_FFFF, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      run_frame("wrap", off, t0);
      if (hlog.size() > 0) check("wrap phase", hlog[0].phase, wrap_exp[i]);
    end

    // Table of masks/latencies with expected FRAME_DONE offsets.
    foreach (tbl[j]) begin
      for (int v = 0; v < VOICES; v++) cfg(v, tbl[j].inc, tbl[j].mask[v], 3'(v));
      lat = tbl[j].lat;
      run_frame("table", off, t0);
      check("table done offset", off, tbl[j].exp_off);
    end

    // Stall voice 2 for 3 cycles, then return results out of order.
    lat = 2;
    for (int v = 0; v < VOICES; v++) cfg(v, 32'h0100_0000, 1'b1, 3'(v));
    hlog.delete();
    model_frame();
    auto_resp = 1'b0; stall_tag = 2'd2; stall_left = 3; stalls = 0; held = '0;
    SAMPLE_TICK = 1'b1;
    cyc_end();
    SAMPLE_TICK = 1'b0;
    n = 0;
    while (hlog.size() < VOICES && n < 60) begin
      if (SH_REQ && SH_TAG == 2'd2 && !SH_RDY) begin
        if (stalls == 0) held = SH_PHASE;
        else check("stall phase hold", SH_PHASE, held);
        check("stall tag hold", SH_TAG, 2'd2);
        stalls++;
      end
      cyc_end();
      n++;
    end
    check("stall cycles", stalls, 3);
    check("stall held phase", held, e_ph[2]);
    check_issues("stall");
    cnt2 = 0;
    foreach (hlog[i]) if (hlog[i].tag == 2'd2) cnt2++;
    check("stall single handshake", cnt2, 1);
    for (int i = 0; i < 4; i++)
      pend.push_back('{cyc + 1 + i, IDX_W'(ooo[i]), shape(e_ph[ooo[i]], e_form[ooo[i]])});
    wait_done(40, "ooo");
    cyc_end();
    check("ooo voice_out", VOICE_OUT, e_out);
    auto_resp = 1'b1;
    run_frame("after stall", off, t0);

    // Overrun: tick during DRAIN, sticky until cleared, set beats clear.
    hlog.delete();
    model_frame();
    auto_resp = 1'b0;
    SAMPLE_TICK = 1'b1;
    cyc_end();
    SAMPLE_TICK = 1'b0;
    n = 0;
    while (hlog.size() < VOICES && n < 40) begin cyc_end(); n++; end
    cyc_end();
    check("drain busy", BUSY, 1'b1);
    check("drain overrun clear", OVERRUN, 1'b0);
    SAMPLE_TICK = 1'b1; cyc_end(); SAMPLE_TICK = 1'b0;
    check("overrun set", OVERRUN, 1'b1);
    cyc_end();
    check("overrun sticky", OVERRUN, 1'b1);
    SAMPLE_TICK = 1'b1; OVR_CLR = 1'b1; cyc_end(); SAMPLE_TICK = 1'b0; OVR_CLR = 1'b0;
    check("overrun set wins clear", OVERRUN, 1'b1);
    OVR_CLR = 1'b1; cyc_end(); OVR_CLR = 1'b0;
    check("overrun cleared", OVERRUN, 1'b0);
    for (int v = 0; v < VOICES; v++)
      pend.push_back('{cyc + 1 + v, IDX_W'(v), shape(e_ph[v], e_form[v])});
    wait_done(40, "overrun");
    cyc_end();
    check("overrun voice_out", VOICE_OUT, e_out);
    check("dropped tick idle", BUSY, 1'b0);
    auto_resp = 1'b1;

    // Reset in the middle of ISSUE.
    SAMPLE_TICK = 1'b1; cyc_end(); SAMPLE_TICK = 1'b0;
    check("mid-issue req", SH_REQ, 1'b1);
    RESET = 1'b0; cyc_end(); RESET = 1'b1;
    check("mid reset busy", BUSY, 1'b0);
    check("mid reset req", SH_REQ, 1'b0);
    check("mid reset voice_out", VOICE_OUT, '0);
    pend.delete(); hlog.delete();
    model_reset();
    for (int v = 0; v < VOICES; v++) cfg(v, 32'h0100_0000, 1'b1, 3'd0);
    run_frame("post reset", off, t0);
    foreach (hlog[i]) check("post reset phase", hlog[i].phase, 32'h0);

    // Random configurations, random ready, random out-of-order returns.
    rand_mode = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int v = 0; v < VOICES; v++)
        if ($urandom_range(3) != 0)
          cfg(v, $urandom, ($urandom_range(3) != 0), 3'($urandom_range(7)));
      run_frame("random", off, t0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dds_voice_scheduler.md
Name: dds_voice_scheduler

Overview:
- Time-shares one waveform-shaper datapath among VOICES independent DDS voices. The shaper is the sine-table / form-wave unit.
- Holds a tuning word, enable and waveform form per voice, plus the per-voice phase accumulators.
- On each sample tick it issues every enabled voice's phase to the shaper through a request/ready handshake and collects the tagged results.
- Results are published to the per-voice output bus atomically, once per frame.

Parameters:
- VOICES, 4, number of voices (power of two, 2..16)
- IDX_W, 2, log2(VOICES); voice index and tag width
- PHASE_W, 32, phase accumulator / tuning word width
- OUT_W, 8, shaper sample width

Ports:
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset; RESET=0 at a rising edge resets
- SAMPLE_TICK  in  1  one-cycle strobe that starts a frame
- CFG_WE  in  1  configuration write strobe
- CFG_ADDR  in  IDX_W  voice index for the write
- CFG_INC  in  PHASE_W  tuning word
- CFG_EN  in  1  voice enable
- CFG_FORM  in  3  waveform form code passed to the shaper
- OVR_CLR  in  1  clears OVERRUN
- SH_REQ  out  1  request to the shaper
- SH_RDY  in  1  shaper accepts the request
- SH_PHASE  out  PHASE_W  phase being issued
- SH_FORM  out  3  form code being issued
- SH_TAG  out  IDX_W  voice index being issued
- SH_VALID  in  1  shaper result valid
- SH_RTAG  in  IDX_W  tag of the returned result
- SH_DATA  in  OUT_W  returned sample
- VOICE_OUT  out  VOICES*OUT_W  published samples; voice i occupies bits [i*OUT_W +: OUT_W]
- FRAME_DONE  out  1  one-cycle pulse when VOICE_OUT updates
- BUSY  out  1  high whenever the state is not IDLE
- OVERRUN  out  1  sticky flag: a tick arrived while BUSY

Behaviour:
- Reset (RESET=0):
  - State returns to IDLE.
  - All phase, inc, en, form and staging registers clear to 0.
  - VOICE_OUT, FRAME_DONE, SH_REQ and OVERRUN go to 0.
  - Outstanding counter and voice pointer clear to 0.
  - Reset mid-frame abandons the frame; any SH_VALID in that cycle is ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - SAMPLE_TICK=1 -> ISSUE with ptr=0.
  - Staging slots of disabled voices clear to 0 in the same edge.
- ISSUE (one slot per voice, ptr ascending):
  - en[ptr]=0: SH_REQ=0, ptr advances next cycle (one cycle consumed).
  - en[ptr]=1: SH_REQ=1, SH_PHASE=phase[ptr] (pre-increment value), SH_FORM=form[ptr], SH_TAG=ptr.
  - Handshake = SH_REQ & SH_RDY. On handshake: phase[ptr] <= phase[ptr]+inc[ptr] mod 2^PHASE_W (wraps silently), outstanding++, ptr++.
  - SH_RDY=0: SH_PHASE, SH_FORM and SH_TAG hold stable; no phase update.
  - After slot VOICES-1 completes -> DRAIN.
- DRAIN: stay until outstanding==0, then -> DONE. A frame with no enabled voices passes straight through DRAIN in one cycle.
- SH_VALID (any state except reset): staging[SH_RTAG] <= SH_DATA, outstanding--.
  - Handshake and SH_VALID in the same cycle leave outstanding unchanged.
  - SH_VALID with outstanding==0 is ignored and does not underflow.
- DONE:
  - VOICE_OUT <= staging (all slots in one edge).
  - FRAME_DONE=1 for exactly this cycle.
  - -> IDLE.
- BUSY=1 in ISSUE, DRAIN and DONE. A tick in DONE counts as overrun.
- Overrun:
  - SAMPLE_TICK while BUSY: tick dropped, OVERRUN <= 1.
  - OVR_CLR clears OVERRUN; a simultaneous new overrun wins (OVERRUN stays 1).
- Configuration:
  - CFG_WE writes inc, en and form for CFG_ADDR at any time.
  - Writing en=0 also clears phase[CFG_ADDR] to 0.
  - A write in the same cycle as that voice's handshake: the handshake uses the old inc/form. The write takes effect from the next cycle, and the en=0 phase clear overrides the increment.
  - A write to a voice whose slot has already been passed takes effect next frame.
- Latency:
  - With all voices enabled, SH_RDY=1 and shaper latency L: tick at cycle T, issues at T+1..T+VOICES, last result at T+VOICES+L.
  - DONE/FRAME_DONE one cycle after the last result: T+VOICES+L+1.
- Shaper responses may arrive out of order; correctness relies on tags only.

Test Plan:
- Reset with all voices enabled (inc=0x01000000) -> VOICE_OUT=0, OVERRUN=0, BUSY=0, no SH_REQ.
- VOICES=4, all enabled, inc=0x01000000, SH_RDY=1, shaper L=2 echoing phase[31:24], tick at T:
  - frame 1 issues SH_PHASE=0 for tags 0..3 at T+1..T+4, FRAME_DONE at T+7;
  - after tick 2, VOICE_OUT slots = 0x01.
- Voice 1 inc=0xFFFFFFFF, starting phase 0x00000002 (reached by loading inc=1 and running two frames, then writing inc=0xFFFFFFFF) -> next issues 0x00000002, 0x00000001, 0x00000000, 0xFFFFFFFF (wraps).
- Voices 1 and 3 disabled -> no SH_REQ in their slots; their VOICE_OUT slots are 0 after FRAME_DONE. Zero voices enabled -> FRAME_DONE at T+VOICES+2.
- SH_RDY held low 3 cycles on voice 2 -> SH_PHASE/SH_TAG stable, phase[2] advances once; out-of-order returns (tags 3,0,2,1) land in the correct slots.
- SAMPLE_TICK during DRAIN -> tick ignored, OVERRUN=1 until OVR_CLR. RESET=0 mid-ISSUE -> IDLE next cycle, phases back to 0.
